// File: rtl/rv_bus_arbiter.sv
// Two-master (I/D) to one-slave bus arbiter for rv_core.
// D has priority, with a starvation limit so that I still makes progress.
// A grant is held until the slave completes, the owner aborts, or the
// watchdog forces completion.

package bus_if_types_pkg;
    typedef enum logic [1:0] {
        READ   = 2'b00,
        WRITE  = 2'b01,
        FETCH  = 2'b10,
        ATOMIC = 2'b11
    } ttype_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } tsize_e;
endpackage

module rv_bus_arbiter
    import bus_if_types_pkg::*;
#(
    parameter int unsigned MAX_CONSEC = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_breq,
    input  logic        i_bstart,
    input  ttype_e      i_ttype,
    input  tsize_e      i_tsize,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_bdone,

    input  logic        d_breq,
    input  logic        d_bstart,
    input  ttype_e      d_ttype,
    input  tsize_e      d_tsize,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_bdone,

    output logic        s_breq,
    output logic        s_bstart,
    output ttype_e      s_ttype,
    output tsize_e      s_tsize,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_bdone,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_e;

    localparam logic [7:0]  MAX_C        = 8'(MAX_CONSEC);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 32'd1);
    localparam bit          WD_EN        = (TIMEOUT != 32'd0);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [7:0]  starve_r;
    logic [7:0]  starve_nxt_s;
    logic [15:0] wd_r;
    logic [15:0] wd_nxt_s;

    logic        in_gnt_s;
    logic        owner_req_s;
    logic        timeout_hit_s;
    logic        complete_s;
    logic        decide_s;

    // Qualify the current cycle: owner still requesting, forced timeout, completion, decision point
    always_comb begin
        in_gnt_s = (state_r != IDLE);
        case (state_r)
            GNT_I:   owner_req_s = i_breq;
            GNT_D:   owner_req_s = d_breq;
            default: owner_req_s = 1'b0;
        endcase
        // A real s_bdone in the same cycle wins over the watchdog
        timeout_hit_s = WD_EN && in_gnt_s && (wd_r == TIMEOUT_LAST) && !s_bdone;
        complete_s    = in_gnt_s && (s_bdone || timeout_hit_s);
        decide_s      = !in_gnt_s || complete_s;
    end

    // Next-state, starvation counter and watchdog counter
    always_comb begin
        state_nxt_s  = state_r;
        starve_nxt_s = starve_r;
        wd_nxt_s     = wd_r;
        if (decide_s) begin
            wd_nxt_s = 16'd0;
            if (d_breq && !(i_breq && (starve_r == MAX_C))) begin
                state_nxt_s = GNT_D;
                if (i_breq) begin
                    if (starve_r < MAX_C) begin
                        starve_nxt_s = starve_r + 8'd1;
                    end else begin
                        starve_nxt_s = starve_r;
                    end
                end else begin
                    starve_nxt_s = 8'd0;
                end
            end else if (i_breq) begin
                state_nxt_s  = GNT_I;
                starve_nxt_s = 8'd0;
            end else begin
                state_nxt_s  = IDLE;
                starve_nxt_s = 8'd0;
            end
        end else if (!owner_req_s) begin
            // Owner abandoned the transfer: release the slave without a bdone
            state_nxt_s = IDLE;
            wd_nxt_s    = 16'd0;
        end else begin
            wd_nxt_s = wd_r + 16'd1;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            starve_r <= 8'd0;
            wd_r     <= 16'd0;
        end else begin
            state_r  <= state_nxt_s;
            starve_r <= starve_nxt_s;
            wd_r     <= wd_nxt_s;
        end
    end

    // Slave-side mux driven from the registered grant; zeros when nobody owns the bus
    always_comb begin
        s_breq   = 1'b0;
        s_bstart = 1'b0;
        s_ttype  = READ;
        s_tsize  = SZ_BYTE;
        s_addr   = 32'd0;
        s_wdata  = 32'd0;
        case (state_r)
            GNT_I: begin
                s_breq   = i_breq;
                s_bstart = i_bstart;
                s_ttype  = i_ttype;
                s_tsize  = i_tsize;
                s_addr   = i_addr;
                s_wdata  = i_wdata;
            end
            GNT_D: begin
                s_breq   = d_breq;
                s_bstart = d_bstart;
                s_ttype  = d_ttype;
                s_tsize  = d_tsize;
                s_addr   = d_addr;
                s_wdata  = d_wdata;
            end
            default: begin
                s_breq   = 1'b0;
                s_bstart = 1'b0;
            end
        endcase
    end

    // Return path: only the owner sees completion; a forced completion returns zero data
    always_comb begin
        grant       = {state_r == GNT_D, state_r == GNT_I};
        i_bdone     = grant[0] && (s_bdone || timeout_hit_s);
        d_bdone     = grant[1] && (s_bdone || timeout_hit_s);
        timeout_err = timeout_hit_s;
        if (timeout_hit_s && grant[0]) begin
            i_rdata = 32'd0;
        end else begin
            i_rdata = s_rdata;
        end
        if (timeout_hit_s && grant[1]) begin
            d_rdata = 32'd0;
        end else begin
            d_rdata = s_rdata;
        end
    end

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Self-checking bench for rv_bus_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.

module tb_rv_bus_arbiter;
    import bus_if_types_pkg::*;

    localparam int MAXC = 4;
    localparam int TMO  = 8;
    localparam logic [31:0] IADDR  = 32'h1000_0040;
    localparam logic [31:0] DADDR  = 32'h8000_0000;
    localparam logic [31:0] RDATAC = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_breq, i_bstart, d_breq, d_bstart;
    ttype_e      i_ttype, d_ttype, s_ttype;
    tsize_e      i_tsize, d_tsize, s_tsize;
    logic [31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
    logic        i_bdone, d_bdone;
    logic        s_breq, s_bstart, s_bdone;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;
    logic        timeout_err;

    always #5 clk = ~clk;

    rv_bus_arbiter #(.MAX_CONSEC(MAXC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_breq(i_breq), .i_bstart(i_bstart), .i_ttype(i_ttype), .i_tsize(i_tsize),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_rdata(i_rdata), .i_bdone(i_bdone),
        .d_breq(d_breq), .d_bstart(d_bstart), .d_ttype(d_ttype), .d_tsize(d_tsize),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_bdone(d_bdone),
        .s_breq(s_breq), .s_bstart(s_bstart), .s_ttype(s_ttype), .s_tsize(s_tsize),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone),
        .grant(grant), .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic quiet_inputs();
        i_breq = 1'b0; i_bstart = 1'b0; i_ttype = READ; i_tsize = SZ_WORD;
        i_addr = IADDR; i_wdata = 32'h0;
        d_breq = 1'b0; d_bstart = 1'b0; d_ttype = READ; d_tsize = SZ_WORD;
        d_addr = DADDR; d_wdata = 32'h0;
        s_bdone = 1'b0; s_rdata = RDATAC;
    endtask

    task automatic chk_quiet_bus(input string tag);
        chk({tag, " grant"}, 64'(grant), 64'd0);
        chk({tag, " s_ctrl"}, 64'({s_breq, s_bstart, s_ttype, s_tsize}), 64'd0);
        chk({tag, " s_addr/wdata"}, 64'({s_addr, s_wdata}), 64'd0);
        chk({tag, " bdones/err"}, 64'({i_bdone, d_bdone, timeout_err}), 64'd0);
    endtask

    typedef struct {
        logic       ib;
        logic       db;
        logic       bd;
        logic [1:0] g;
        logic       ibd;
        logic       dbd;
    } vec_t;

    vec_t tbl[18];

    // behavioural reference state: who owns the bus, D grants in a row while I waits, cycles held
    int m_owner;
    int m_streak;
    int m_age;

    initial begin
        logic [31:0] exp_addr;
        int          hit_k;
        logic        early_ok;
        logic        forced, done, ireq_own;
        int          bd_pct;

        // I-only transfer, bdone two cycles after bstart, then a return to idle
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        // both requesting, slave done every cycle: D,D,D,D,I,D,D,D,D,I,D
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

        quiet_inputs();

        // reset with both requests low, then release
        #12;
        chk_quiet_bus("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk_quiet_bus("post-reset");

        // directed vector table
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            i_breq = tbl[k].ib; i_bstart = tbl[k].ib;
            d_breq = tbl[k].db; d_bstart = tbl[k].db;
            s_bdone = tbl[k].bd;
            #1;
            exp_addr = (tbl[k].g == 2'b01) ? IADDR : ((tbl[k].g == 2'b10) ? DADDR : 32'd0);
            chk($sformatf("tbl%0d grant", k), 64'(grant), 64'(tbl[k].g));
            chk($sformatf("tbl%0d bdones/err", k), 64'({i_bdone, d_bdone, timeout_err}),
                64'({tbl[k].ibd, tbl[k].dbd, 1'b0}));
            chk($sformatf("tbl%0d s_addr", k), 64'(s_addr), 64'(exp_addr));
            if (tbl[k].ibd) chk($sformatf("tbl%0d i_rdata", k), 64'(i_rdata), 64'(RDATAC));
        end

        // D write issued while I owns the bus waits for I's completion
        @(negedge clk);
        quiet_inputs();
        i_breq = 1'b1; i_bstart = 1'b1;
        #1;
        chk("dwait idle", 64'(grant), 64'd0);
        @(negedge clk);
        d_breq = 1'b1; d_bstart = 1'b1; d_ttype = WRITE; d_tsize = SZ_WORD;
        d_addr = 32'h8000_0010; d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("dwait held by I", 64'({grant, s_addr}), 64'({2'b01, IADDR}));
        @(negedge clk);
        #1;
        chk("dwait still I", 64'(grant), 64'd1);
        @(negedge clk);
        s_bdone = 1'b1;
        #1;
        chk("dwait I done", 64'({i_bdone, d_bdone}), 64'({1'b1, 1'b0}));
        @(negedge clk);
        s_bdone = 1'b0;
        #1;
        chk("dwait D grant", 64'(grant), 64'd2);
        chk("dwait D addr/wdata", 64'({s_addr, s_wdata}), 64'({32'h8000_0010, 32'hDEAD_BEEF}));
        chk("dwait D ttype", 64'(s_ttype), 64'(WRITE));
        @(negedge clk);
        s_bdone = 1'b1; i_breq = 1'b0; i_bstart = 1'b0; d_breq = 1'b0; d_bstart = 1'b0;
        #1;
        chk("dwait D done w/ drop", 64'({i_bdone, d_bdone}), 64'({1'b0, 1'b1}));
        @(negedge clk);
        s_bdone = 1'b0;
        #1;
        chk("dwait back idle", 64'(grant), 64'd0);

        // watchdog: slave never answers an I read
        @(negedge clk);
        s_rdata = 32'hFFFF_FFFF;
        i_breq = 1'b1; i_bstart = 1'b1;
        hit_k = -1;
        early_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            if (timeout_err) begin
                hit_k = k;
                chk("tmo bdone", 64'({i_bdone, d_bdone}), 64'({1'b1, 1'b0}));
                chk("tmo rdata zero", 64'(i_rdata), 64'd0);
                break;
            end else begin
                if (grant != 2'b01 || i_bdone) early_ok = 1'b0;
            end
        end
        chk("tmo cycle", 64'(hit_k), 64'(TMO));
        chk("tmo waiting cycles", 64'(early_ok), 64'd1);
        @(negedge clk);
        #1;
        chk("tmo one-cycle pulse", 64'(timeout_err), 64'd0);
        chk("tmo regrant", 64'(grant), 64'd1);
        @(negedge clk);
        i_breq = 1'b0; i_bstart = 1'b0;
        #1;
        chk("abort no bdone", 64'({i_bdone, timeout_err}), 64'd0);
        @(negedge clk);
        #1;
        chk("abort idle", 64'(grant), 64'd0);
        s_rdata = RDATAC;

        // asynchronous reset in the middle of a D grant
        @(negedge clk);
        d_breq = 1'b1; d_bstart = 1'b1;
        @(negedge clk);
        #1;
        chk("rst mid grant", 64'({grant, s_bstart}), 64'({2'b10, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async drop", 64'({grant, s_bstart, d_bdone}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst release idle", 64'(grant), 64'd0);
        @(negedge clk);
        #1;
        chk("rst regrant D", 64'(grant), 64'd2);

        // re-sync with the reference model via reset, then random traffic
        @(negedge clk);
        quiet_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_owner = 0; m_streak = 0; m_age = 0;
        bd_pct = 50;
        for (int c = 0; c < 2400; c++) begin
            @(negedge clk);
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: bd_pct = 50;
                    1: bd_pct = 5;
                    2: bd_pct = 100;
                    default: bd_pct = 0;
                endcase
            end
            if ($urandom_range(0, 99) < 15) i_breq = ~i_breq;
            if ($urandom_range(0, 99) < 15) d_breq = ~d_breq;
            i_bstart = i_breq; d_bstart = d_breq;
            i_ttype = ttype_e'($urandom_range(0, 3)); i_tsize = tsize_e'($urandom_range(0, 3));
            d_ttype = ttype_e'($urandom_range(0, 3)); d_tsize = tsize_e'($urandom_range(0, 3));
            i_addr = $urandom; i_wdata = $urandom; d_addr = $urandom; d_wdata = $urandom;
            s_rdata = $urandom;
            s_bdone = ($urandom_range(0, 99) < bd_pct);
            #1;

            forced = (m_owner != 0) && (m_age == TMO - 1) && !s_bdone;
            done   = (m_owner != 0) && (s_bdone || forced);
            chk($sformatf("rnd%0d grant", c), 64'(grant),
                (m_owner == 1) ? 64'd1 : ((m_owner == 2) ? 64'd2 : 64'd0));
            chk($sformatf("rnd%0d bdones/err", c), 64'({i_bdone, d_bdone, timeout_err}),
                64'({(m_owner == 1) && done, (m_owner == 2) && done, forced}));
            chk($sformatf("rnd%0d rdata", c), 64'({i_rdata, d_rdata}),
                64'({((m_owner == 1) && forced) ? 32'd0 : s_rdata,
                     ((m_owner == 2) && forced) ? 32'd0 : s_rdata}));
            if (m_owner == 1) begin
                chk($sformatf("rnd%0d s_bus", c),
                    {s_breq, s_bstart, s_ttype, s_tsize, s_addr, s_wdata[25:0]},
                    {i_breq, i_bstart, i_ttype, i_tsize, i_addr, i_wdata[25:0]});
            end else if (m_owner == 2) begin
                chk($sformatf("rnd%0d s_bus", c),
                    {s_breq, s_bstart, s_ttype, s_tsize, s_addr, s_wdata[25:0]},
                    {d_breq, d_bstart, d_ttype, d_tsize, d_addr, d_wdata[25:0]});
            end else begin
                chk($sformatf("rnd%0d s_bus", c),
                    {s_breq, s_bstart, s_ttype, s_tsize, s_addr, s_wdata[25:0]}, 64'd0);
            end

            // advance the model by the arbitration rules
            ireq_own = (m_owner == 1) ? i_breq : d_breq;
            if (m_owner == 0 || done) begin
                m_age = 0;
                if (d_breq && !(i_breq && m_streak >= MAXC)) begin
                    m_owner  = 2;
                    m_streak = i_breq ? ((m_streak + 1 > MAXC) ? MAXC : m_streak + 1) : 0;
                end else if (i_breq) begin
                    m_owner  = 1;
                    m_streak = 0;
                end else begin
                    m_owner  = 0;
                    m_streak = 0;
                end
            end else if (!ireq_own) begin
                m_owner = 0;
                m_age   = 0;
            end else begin
                m_age++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
